// File: rtl/cv32e40p_localparam_pkg.sv
// Core-wide sizing constants shared by the hardware-loop logic.
package cv32e40p_localparam_pkg;

   localparam int unsigned N_HWLP      = 2;
   localparam int unsigned N_HWLP_BITS = $clog2(N_HWLP);

endpackage

// File: rtl/cv32e40p_pkg.sv
// Hardware-loop write-enable bit positions, readback selects and address helper.
package cv32e40p_pkg;

   localparam int unsigned HWLP_WE_START = 0;
   localparam int unsigned HWLP_WE_END   = 1;
   localparam int unsigned HWLP_WE_COUNT = 2;

   typedef enum logic [1:0] {
      HWLP_RSEL_START = 2'd0,
      HWLP_RSEL_END   = 2'd1,
      HWLP_RSEL_COUNT = 2'd2,
      HWLP_RSEL_RSVD  = 2'd3
   } hwlp_rsel_e;

   function automatic logic [31:0] hwlp_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/cv32e40p_hwlp_unit_if.sv
// Bundle of the decoder/CSR write path, ID retire info and IF redirect signals.
interface cv32e40p_hwlp_unit_if;
   import cv32e40p_localparam_pkg::*;

   logic [2:0]             hwlp_we_i;
   logic [N_HWLP_BITS-1:0] hwlp_regid_i;
   logic [31:0]            hwlp_wdata_i;
   logic [1:0]             hwlp_raddr_i;
   logic [N_HWLP_BITS-1:0] hwlp_rregid_i;
   logic [31:0]            hwlp_rdata_o;
   logic [31:0]            id_pc_i;
   logic                   id_valid_i;
   logic                   hwlp_jump_o;
   logic [31:0]            hwlp_target_o;
   logic [N_HWLP-1:0]      hwlp_busy_o;

   modport slave (
      input  hwlp_we_i, hwlp_regid_i, hwlp_wdata_i, hwlp_raddr_i, hwlp_rregid_i,
             id_pc_i, id_valid_i,
      output hwlp_rdata_o, hwlp_jump_o, hwlp_target_o, hwlp_busy_o
   );

   modport master (
      output hwlp_we_i, hwlp_regid_i, hwlp_wdata_i, hwlp_raddr_i, hwlp_rregid_i,
             id_pc_i, id_valid_i,
      input  hwlp_rdata_o, hwlp_jump_o, hwlp_target_o, hwlp_busy_o
   );

endinterface

// File: rtl/cv32e40p_hwlp_regs.sv
// Loop start/end/count register array with write-versus-decrement arbitration.
module cv32e40p_hwlp_regs
   import cv32e40p_localparam_pkg::*;
   import cv32e40p_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [2:0]                   we,
   input  logic [N_HWLP_BITS-1:0]       regid,
   input  logic [31:0]                  wdata,
   input  logic [N_HWLP-1:0]            dec,
   output logic [N_HWLP-1:0][31:0]      loop_start,
   output logic [N_HWLP-1:0][31:0]      loop_end,
   output logic [N_HWLP-1:0][31:0]      loop_count
);

   logic [N_HWLP-1:0] hit;

   // An out-of-range regid matches no entry, so the write is dropped.
   always_comb begin
      hit = '0;
      for (int unsigned i = 0; i < N_HWLP; i++) begin
         hit[i] = (regid == N_HWLP_BITS'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         loop_start <= '0;
         loop_end   <= '0;
         loop_count <= '0;
      end else begin
         for (int unsigned i = 0; i < N_HWLP; i++) begin
            if (we[HWLP_WE_START] && hit[i]) loop_start[i] <= hwlp_align(wdata);
            if (we[HWLP_WE_END] && hit[i])   loop_end[i]   <= hwlp_align(wdata);
            // A count write overrides a same-cycle decrement.
            if (we[HWLP_WE_COUNT] && hit[i]) begin
               loop_count[i] <= wdata;
            end else if (dec[i] && (loop_count[i] != '0)) begin
               loop_count[i] <= loop_count[i] - 32'd1;
            end
         end
      end
   end

endmodule

// File: rtl/cv32e40p_hwlp_unit.sv
// Hardware-loop unit: loop-end match, innermost-first priority, redirect and readback.
module cv32e40p_hwlp_unit
   import cv32e40p_localparam_pkg::*;
   import cv32e40p_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   cv32e40p_hwlp_unit_if.slave  bus
);

   logic [N_HWLP-1:0][31:0] loop_start;
   logic [N_HWLP-1:0][31:0] loop_end;
   logic [N_HWLP-1:0][31:0] loop_count;
   logic [N_HWLP-1:0]       match;
   logic [N_HWLP-1:0]       dec;
   logic                    found;
   logic [31:0]             win_start;
   logic [31:0]             win_count;
   logic                    jump;
   logic [N_HWLP-1:0]       busy;
   logic [31:0]             rdata;

   cv32e40p_hwlp_regs regs (
      .clk        (clk),
      .rst        (rst),
      .we         (bus.hwlp_we_i),
      .regid      (bus.hwlp_regid_i),
      .wdata      (bus.hwlp_wdata_i),
      .dec        (dec),
      .loop_start (loop_start),
      .loop_end   (loop_end),
      .loop_count (loop_count)
   );

   // Lowest index is the innermost loop and takes the match exclusively.
   always_comb begin
      match     = '0;
      dec       = '0;
      found     = 1'b0;
      win_start = '0;
      win_count = '0;
      for (int unsigned i = 0; i < N_HWLP; i++) begin
         match[i] = bus.id_valid_i && !rst && (loop_count[i] != '0) &&
                    (bus.id_pc_i == loop_end[i]);
      end
      for (int unsigned i = 0; i < N_HWLP; i++) begin
         if (match[i] && !found) begin
            found     = 1'b1;
            dec[i]    = 1'b1;
            win_start = loop_start[i];
            win_count = loop_count[i];
         end
      end
   end

   always_comb begin
      jump = found && (win_count > 32'd1);
      busy = '0;
      for (int unsigned i = 0; i < N_HWLP; i++) begin
         busy[i] = !rst && (loop_count[i] != '0);
      end
   end

   always_comb begin
      rdata = '0;
      for (int unsigned i = 0; i < N_HWLP; i++) begin
         if (bus.hwlp_rregid_i == N_HWLP_BITS'(i)) begin
            case (hwlp_rsel_e'(bus.hwlp_raddr_i))
               HWLP_RSEL_START: rdata = loop_start[i];
               HWLP_RSEL_END:   rdata = loop_end[i];
               HWLP_RSEL_COUNT: rdata = loop_count[i];
               default:         rdata = '0;
            endcase
         end
      end
   end

   assign bus.hwlp_jump_o   = jump;
   assign bus.hwlp_target_o = jump ? win_start : '0;
   assign bus.hwlp_busy_o   = busy;
   assign bus.hwlp_rdata_o  = rdata;

endmodule

// File: tb/tb_cv32e40p_hwlp_unit.sv
// Directed-vector bench for the hardware-loop unit.
module tb_cv32e40p_hwlp_unit;
   import cv32e40p_localparam_pkg::*;

   typedef struct {
      logic                   rst;
      logic [2:0]             we;
      logic [N_HWLP_BITS-1:0] regid;
      logic [31:0]            wdata;
      logic [1:0]             raddr;
      logic [N_HWLP_BITS-1:0] rregid;
      logic [31:0]            pc;
      logic                   valid;
      logic                   jump;
      logic [31:0]            target;
      logic [N_HWLP-1:0]      busy;
      logic [31:0]            rdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   vec_count  = 0;
   int   miscompares = 0;

   cv32e40p_hwlp_unit_if bus();

   cv32e40p_hwlp_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [2:0] we, input logic rg,
                               input logic [31:0] wd, input logic [1:0] ra, input logic rr,
                               input logic [31:0] pc, input logic v, input logic j,
                               input logic [31:0] t, input logic [1:0] b, input logic [31:0] rd);
      vec_t x;
      x.rst = r;  x.we = we; x.regid = rg; x.wdata = wd; x.raddr = ra; x.rregid = rr;
      x.pc = pc;  x.valid = v; x.jump = j; x.target = t; x.busy = b; x.rdata = rd;
      return x;
   endfunction

   // Drive one cycle of inputs, check outputs mid-cycle, then clock it in.
   task automatic apply(input vec_t x, input string tag);
      rst               = x.rst;
      bus.hwlp_we_i     = x.we;
      bus.hwlp_regid_i  = x.regid;
      bus.hwlp_wdata_i  = x.wdata;
      bus.hwlp_raddr_i  = x.raddr;
      bus.hwlp_rregid_i = x.rregid;
      bus.id_pc_i       = x.pc;
      bus.id_valid_i    = x.valid;
      #3;
      vec_count++;
      if (bus.hwlp_jump_o !== x.jump || bus.hwlp_target_o !== x.target ||
          bus.hwlp_busy_o !== x.busy || bus.hwlp_rdata_o !== x.rdata) begin
         miscompares++;
         $display("FAIL %s: got jump=%b target=%h busy=%b rdata=%h, want jump=%b target=%h busy=%b rdata=%h",
                  tag, bus.hwlp_jump_o, bus.hwlp_target_o, bus.hwlp_busy_o, bus.hwlp_rdata_o,
                  x.jump, x.target, x.busy, x.rdata);
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[30];

   initial begin
      //               rst we      rg wdata         ra    rr pc            v  j  target        busy   rdata
      tbl[0]  = mk(1, 3'b000, 0, 32'h0,       2'd0, 0, 32'h0,     0, 0, 32'h0,     2'b00, 32'h0);
      tbl[1]  = mk(0, 3'b001, 0, 32'h100,     2'd0, 0, 32'h0,     0, 0, 32'h0,     2'b00, 32'h0);
      tbl[2]  = mk(0, 3'b010, 0, 32'h10C,     2'd0, 0, 32'h0,     0, 0, 32'h0,     2'b00, 32'h100);
      tbl[3]  = mk(0, 3'b100, 0, 32'd3,       2'd1, 0, 32'h0,     0, 0, 32'h0,     2'b00, 32'h10C);
      tbl[4]  = mk(0, 3'b000, 0, 32'h0,       2'd2, 0, 32'h10C,   1, 1, 32'h100,   2'b01, 32'd3);
      tbl[5]  = mk(0, 3'b000, 0, 32'h0,       2'd2, 0, 32'h10C,   1, 1, 32'h100,   2'b01, 32'd2);
      tbl[6]  = mk(0, 3'b000, 0, 32'h0,       2'd2, 0, 32'h10C,   1, 0, 32'h0,     2'b01, 32'd1);
      tbl[7]  = mk(0, 3'b000, 0, 32'h0,       2'd2, 0, 32'h10C,   1, 0, 32'h0,     2'b00, 32'd0);
      tbl[8]  = mk(0, 3'b001, 0, 32'h1F0,     2'd3, 0, 32'h0,     0, 0, 32'h0,     2'b00, 32'h0);
      tbl[9]  = mk(0, 3'b010, 0, 32'h200,     2'd0, 0, 32'h0,     0, 0, 32'h0,     2'b00, 32'h1F0);
      tbl[10] = mk(0, 3'b100, 0, 32'd2,       2'd1, 0, 32'h0,     0, 0, 32'h0,     2'b00, 32'h200);
      tbl[11] = mk(0, 3'b001, 1, 32'h1E0,     2'd2, 0, 32'h0,     0, 0, 32'h0,     2'b01, 32'd2);
      tbl[12] = mk(0, 3'b010, 1, 32'h200,     2'd0, 1, 32'h0,     0, 0, 32'h0,     2'b01, 32'h1E0);
      tbl[13] = mk(0, 3'b100, 1, 32'd2,       2'd1, 1, 32'h0,     0, 0, 32'h0,     2'b01, 32'h200);
      tbl[14] = mk(0, 3'b000, 0, 32'h0,       2'd2, 1, 32'h200,   1, 1, 32'h1F0,   2'b11, 32'd2);
      tbl[15] = mk(0, 3'b000, 0, 32'h0,       2'd2, 1, 32'h0,     0, 0, 32'h0,     2'b11, 32'd2);
      tbl[16] = mk(0, 3'b000, 0, 32'h0,       2'd2, 0, 32'h0,     0, 0, 32'h0,     2'b11, 32'd1);
      tbl[17] = mk(0, 3'b000, 0, 32'h0,       2'd2, 0, 32'h200,   1, 0, 32'h0,     2'b11, 32'd1);
      tbl[18] = mk(0, 3'b000, 0, 32'h0,       2'd2, 1, 32'h200,   1, 1, 32'h1E0,   2'b10, 32'd2);
      tbl[19] = mk(0, 3'b000, 0, 32'h0,       2'd2, 1, 32'h200,   1, 0, 32'h0,     2'b10, 32'd1);
      tbl[20] = mk(0, 3'b000, 0, 32'h0,       2'd2, 1, 32'h0,     0, 0, 32'h0,     2'b00, 32'd0);
      tbl[21] = mk(0, 3'b100, 0, 32'd5,       2'd2, 0, 32'h0,     0, 0, 32'h0,     2'b00, 32'd0);
      tbl[22] = mk(0, 3'b100, 0, 32'd9,       2'd2, 0, 32'h200,   1, 1, 32'h1F0,   2'b01, 32'd5);
      tbl[23] = mk(0, 3'b000, 0, 32'h0,       2'd2, 0, 32'h0,     0, 0, 32'h0,     2'b01, 32'd9);
      tbl[24] = mk(0, 3'b001, 0, 32'h1003,    2'd0, 0, 32'h200,   1, 1, 32'h1F0,   2'b01, 32'h1F0);
      tbl[25] = mk(0, 3'b000, 0, 32'h0,       2'd0, 0, 32'h0,     0, 0, 32'h0,     2'b01, 32'h1000);
      tbl[26] = mk(0, 3'b000, 0, 32'h0,       2'd2, 0, 32'h0,     0, 0, 32'h0,     2'b01, 32'd8);
      tbl[27] = mk(0, 3'b100, 1, 32'd7,       2'd2, 0, 32'h200,   1, 1, 32'h1000,  2'b01, 32'd8);
      tbl[28] = mk(0, 3'b000, 0, 32'h0,       2'd2, 0, 32'h0,     0, 0, 32'h0,     2'b11, 32'd7);
      tbl[29] = mk(0, 3'b000, 0, 32'h0,       2'd2, 1, 32'h0,     0, 0, 32'h0,     2'b11, 32'd7);

      // Unchecked cycle to bring registers out of their power-up state.
      rst = 1'b1;
      bus.hwlp_we_i = '0; bus.hwlp_regid_i = '0; bus.hwlp_wdata_i = '0;
      bus.hwlp_raddr_i = '0; bus.hwlp_rregid_i = '0; bus.id_pc_i = '0; bus.id_valid_i = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 30; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

      // Stall: a retiring-PC match without id_valid must not act.
      apply(mk(0, 3'b100, 0, 32'd2, 2'd2, 0, 32'h0,   0, 0, 32'h0,    2'b11, 32'd7), "stall_load");
      for (int i = 0; i < 5; i++)
         apply(mk(0, 3'b000, 0, 32'h0, 2'd2, 0, 32'h200, 0, 0, 32'h0, 2'b11, 32'd2), $sformatf("stall_hold%0d", i));
      apply(mk(0, 3'b000, 0, 32'h0,   2'd2, 0, 32'h200, 1, 1, 32'h1000, 2'b11, 32'd2), "stall_release");
      apply(mk(0, 3'b000, 0, 32'h0,   2'd2, 0, 32'h0,   0, 0, 32'h0,    2'b11, 32'd1), "stall_after");

      // Reset in the middle of an active loop.
      apply(mk(0, 3'b100, 0, 32'd4, 2'd2, 0, 32'h0,   0, 0, 32'h0,    2'b11, 32'd1), "rst_load");
      apply(mk(0, 3'b000, 0, 32'h0, 2'd2, 0, 32'h200, 1, 1, 32'h1000, 2'b11, 32'd4), "rst_iter");
      apply(mk(1, 3'b000, 0, 32'h0, 2'd2, 0, 32'h200, 1, 0, 32'h0,    2'b00, 32'd3), "rst_cycle");
      apply(mk(0, 3'b000, 0, 32'h0, 2'd0, 0, 32'h0,   0, 0, 32'h0,    2'b00, 32'h0), "rst_start0");
      apply(mk(0, 3'b000, 0, 32'h0, 2'd1, 0, 32'h0,   0, 0, 32'h0,    2'b00, 32'h0), "rst_end0");
      apply(mk(0, 3'b000, 0, 32'h0, 2'd2, 0, 32'h0,   0, 0, 32'h0,    2'b00, 32'h0), "rst_count0");
      apply(mk(0, 3'b000, 0, 32'h0, 2'd0, 1, 32'h0,   0, 0, 32'h0,    2'b00, 32'h0), "rst_start1");
      apply(mk(0, 3'b000, 0, 32'h0, 2'd2, 1, 32'h200, 1, 0, 32'h0,    2'b00, 32'h0), "rst_nojump200");
      apply(mk(0, 3'b000, 0, 32'h0, 2'd1, 1, 32'h0,   1, 0, 32'h0,    2'b00, 32'h0), "rst_nojump0");

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
